// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory port.
// The arbiter takes the slave side; the core/memory environment takes the master side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_func3;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_func3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_read, mem_write, mem_addr, mem_func3, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_func3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_read, mem_write, mem_addr, mem_func3, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port data memory shared between instruction fetch and load/store.
// Data port has priority; a streak counter forces a fetch grant after STREAK_MAX data wins.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int STREAK_MAX = 4
) (
    input logic                  clk,
    input logic                  rst,
    unified_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    owner_t            owner_q, owner_d;
    logic [SW-1:0]     streak_q;
    logic              streak_full;
    logic              if_gnt_c, d_gnt_c;
    logic              if_err_c, d_err_c;
    logic [ADDR_W-1:0] d_addr_c;
    logic [31:0]       if_rdata_q, d_rdata_q;
    logic              if_err_q, d_err_q;

    assign d_addr_c    = bus.d_addr;
    assign streak_full = (streak_q == SW'(STREAK_MAX));

    // Grants are suppressed while reset is held so nothing reaches memory.
    assign if_gnt_c = !rst && bus.if_req && (!bus.d_req || streak_full);
    assign d_gnt_c  = !rst && bus.d_req && !if_gnt_c;

    assign if_err_c = |bus.if_addr[1:0];

    always_comb begin
        d_err_c = 1'b0;
        case (bus.d_func3)
            3'b010:         d_err_c = |d_addr_c[1:0];
            3'b001, 3'b101: d_err_c = d_addr_c[0];
            default:        d_err_c = 1'b0;
        endcase
        if (bus.d_we && !(bus.d_func3 inside {3'b000, 3'b001, 3'b010}))
            d_err_c = 1'b1;
        if (!bus.d_we && (bus.d_func3 inside {3'b011, 3'b110, 3'b111}))
            d_err_c = 1'b1;
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_func3 = 3'b000;
        bus.mem_wdata = 32'd0;
        if (if_gnt_c && !if_err_c) begin
            bus.mem_read  = 1'b1;
            bus.mem_func3 = 3'b010;
            bus.mem_addr  = bus.if_addr;
        end else if (d_gnt_c && !d_err_c) begin
            bus.mem_read  = !bus.d_we;
            bus.mem_write = bus.d_we;
            bus.mem_func3 = bus.d_func3;
            bus.mem_addr  = d_addr_c;
            bus.mem_wdata = bus.d_we ? bus.d_wdata : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end

    always_comb begin
        owner_d       = OWN_NONE;
        bus.if_gnt    = if_gnt_c;
        bus.d_gnt     = d_gnt_c;
        bus.if_rvalid = (owner_q == OWN_IF);
        bus.d_rvalid  = (owner_q == OWN_D);
        if (if_gnt_c)     owner_d = OWN_IF;
        else if (d_gnt_c) owner_d = OWN_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       streak_q <= '0;
        else if (d_gnt_c && bus.if_req) streak_q <= streak_full ? streak_q : streak_q + 1'b1;
        else                           streak_q <= '0;
    end

    // Response payloads are captured on the grant edge and held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= 32'd0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_err_q    <= 1'b0;
        end else begin
            if (if_gnt_c) begin
                if_err_q   <= if_err_c;
                if_rdata_q <= if_err_c ? 32'd0 : bus.mem_rdata;
            end
            if (d_gnt_c) begin
                d_err_q <= d_err_c;
                if (d_err_c)        d_rdata_q <= 32'd0;
                else if (!bus.d_we) d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_rdata = if_rdata_q;
    assign bus.if_err   = if_err_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: byte memory model behind the arbiter and a response scoreboard.
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_arbiter_if #(.ADDR_W(8)) bus ();

    unified_mem_arbiter #(.ADDR_W(8), .STREAK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory with combinational reads (width/sign by func3) and posedge writes.
    logic [7:0] mem_arr [256];
    logic [7:0] rb0, rb1, rb2, rb3;

    always_comb begin
        rb0 = mem_arr[bus.mem_addr];
        rb1 = mem_arr[8'(bus.mem_addr + 8'd1)];
        rb2 = mem_arr[8'(bus.mem_addr + 8'd2)];
        rb3 = mem_arr[8'(bus.mem_addr + 8'd3)];
        case (bus.mem_func3)
            3'b000:  bus.mem_rdata = {{24{rb0[7]}}, rb0};
            3'b001:  bus.mem_rdata = {{16{rb1[7]}}, rb1, rb0};
            3'b010:  bus.mem_rdata = {rb3, rb2, rb1, rb0};
            3'b100:  bus.mem_rdata = {24'd0, rb0};
            3'b101:  bus.mem_rdata = {16'd0, rb1, rb0};
            default: bus.mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata[7:0];
            if (bus.mem_func3 != 3'b000)
                mem_arr[8'(bus.mem_addr + 8'd1)] <= bus.mem_wdata[15:8];
            if (bus.mem_func3 == 3'b010) begin
                mem_arr[8'(bus.mem_addr + 8'd2)] <= bus.mem_wdata[23:16];
                mem_arr[8'(bus.mem_addr + 8'd3)] <= bus.mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        chk;
        int          cyc;
    } exp_t;

    exp_t if_q [$];
    exp_t d_q  [$];

    function automatic void push_if(input logic err, input logic [31:0] rdata);
        exp_t e;
        e.err = err; e.rdata = rdata; e.chk = 1'b1; e.cyc = cyc + 1;
        if_q.push_back(e);
    endfunction

    function automatic void push_d(input logic err, input logic [31:0] rdata, input logic chk);
        exp_t e;
        e.err = err; e.rdata = rdata; e.chk = chk; e.cyc = cyc + 1;
        d_q.push_back(e);
    endfunction

    // Scoreboard: each granted request expects exactly one response on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.if_rvalid) begin
            tests_run++;
            if (if_q.size() == 0) begin
                tests_failed++;
                $display("FAIL if_unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
            end else begin
                e = if_q.pop_front();
                if (bus.if_err !== e.err || (e.chk && bus.if_rdata !== e.rdata) || cyc != e.cyc) begin
                    tests_failed++;
                    $display("FAIL if_response: got err=%b rdata=%08h cycle=%0d, required err=%b rdata=%08h cycle=%0d",
                             bus.if_err, bus.if_rdata, cyc, e.err, e.rdata, e.cyc);
                end
            end
        end else if (if_q.size() != 0 && if_q[0].cyc <= cyc) begin
            tests_run++;
            tests_failed++;
            e = if_q.pop_front();
            $display("FAIL if_missing_rvalid: got rvalid=0 at cycle %0d, required 1", e.cyc);
        end
        if (bus.d_rvalid) begin
            tests_run++;
            if (d_q.size() == 0) begin
                tests_failed++;
                $display("FAIL d_unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
            end else begin
                e = d_q.pop_front();
                if (bus.d_err !== e.err || (e.chk && bus.d_rdata !== e.rdata) || cyc != e.cyc) begin
                    tests_failed++;
                    $display("FAIL d_response: got err=%b rdata=%08h cycle=%0d, required err=%b rdata=%08h cycle=%0d",
                             bus.d_err, bus.d_rdata, cyc, e.err, e.rdata, e.cyc);
                end
            end
        end else if (d_q.size() != 0 && d_q[0].cyc <= cyc) begin
            tests_run++;
            tests_failed++;
            e = d_q.pop_front();
            $display("FAIL d_missing_rvalid: got rvalid=0 at cycle %0d, required 1", e.cyc);
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_func3 = f3;
        bus.d_addr  = a;
        bus.d_wdata = wd;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b1; bus.if_addr = 8'h00;
        drive_d(1'b1, 3'b010, 8'h40, 32'hAAAA5555);
        @(negedge clk);
        tests_run++;
        if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_gnt: got if_gnt=%b d_gnt=%b rd=%b wr=%b, required all 0",
                     bus.if_gnt, bus.d_gnt, bus.mem_read, bus.mem_write);
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.if_err !== 1'b0 || bus.d_err !== 1'b0 ||
            bus.if_rdata !== 32'd0 || bus.d_rdata !== 32'd0 || bus.mem_addr !== 8'd0 || bus.mem_wdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rv=%b/%b err=%b/%b rdata=%08h/%08h addr=%02h, required all 0",
                     bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err, bus.if_rdata, bus.d_rdata, bus.mem_addr);
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 8'h00;
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_func3 !== 3'b010 || bus.mem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL fetch_grant: got gnt=%b rd=%b f3=%b addr=%02h, required 1 1 010 00",
                     bus.if_gnt, bus.mem_read, bus.mem_func3, bus.mem_addr);
        end
        push_if(1'b0, 32'h00040914);
        idle();
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b0 || bus.mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_idle: got gnt=%b rd=%b, required 0 0", bus.if_gnt, bus.mem_read);
        end
    endtask

    task automatic test_streak();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 8'h00;
            drive_d(1'b0, 3'b010, 8'h04, 32'd0);
            #1;
            tests_run++;
            if (bus.if_gnt !== (i == 5) || bus.d_gnt !== (i != 5)) begin
                tests_failed++;
                $display("FAIL streak_cycle%0d: got if_gnt=%b d_gnt=%b, required %b %b",
                         i, bus.if_gnt, bus.d_gnt, (i == 5), (i != 5));
            end
            if (i == 5) push_if(1'b0, 32'h00040914);
            else        push_d(1'b0, 32'hCAFEF00D, 1'b1);
        end
        idle();
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive_d(1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
        #1;
        tests_run++;
        if (bus.d_gnt !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 ||
            bus.mem_wdata !== 32'hDEADBEEF || bus.mem_addr !== 8'h10) begin
            tests_failed++;
            $display("FAIL sw_drive: got gnt=%b wr=%b rd=%b wdata=%08h addr=%02h, required 1 1 0 deadbeef 10",
                     bus.d_gnt, bus.mem_write, bus.mem_read, bus.mem_wdata, bus.mem_addr);
        end
        push_d(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        drive_d(1'b0, 3'b000, 8'h13, 32'd0);
        push_d(1'b0, 32'hFFFFFFDE, 1'b1);
        @(negedge clk);
        drive_d(1'b0, 3'b100, 8'h13, 32'd0);
        push_d(1'b0, 32'h000000DE, 1'b1);
        @(negedge clk);
        drive_d(1'b0, 3'b010, 8'h10, 32'd0);
        push_d(1'b0, 32'hDEADBEEF, 1'b1);
        idle();
    endtask

    task automatic test_errors();
        @(negedge clk);
        drive_d(1'b0, 3'b010, 8'h02, 32'd0);
        #1;
        tests_run++;
        if (bus.d_gnt !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_misaligned_drive: got gnt=%b rd=%b wr=%b, required 1 0 0",
                     bus.d_gnt, bus.mem_read, bus.mem_write);
        end
        push_d(1'b1, 32'd0, 1'b1);
        @(negedge clk);
        drive_d(1'b1, 3'b100, 8'h20, 32'h11223344);
        #1;
        tests_run++;
        if (bus.d_gnt !== 1'b1 || bus.mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_bad_func3: got gnt=%b wr=%b, required 1 0", bus.d_gnt, bus.mem_write);
        end
        push_d(1'b1, 32'd0, 1'b1);
        @(negedge clk);
        drive_d(1'b0, 3'b001, 8'h21, 32'd0);
        push_d(1'b1, 32'd0, 1'b1);
        @(negedge clk);
        drive_d(1'b0, 3'b011, 8'h00, 32'd0);
        push_d(1'b1, 32'd0, 1'b1);
        @(negedge clk);
        bus.d_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 8'h01;
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b1 || bus.mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL if_misaligned_drive: got gnt=%b rd=%b, required 1 0", bus.if_gnt, bus.mem_read);
        end
        push_if(1'b1, 32'd0);
        idle();
    endtask

    task automatic test_halfword();
        @(negedge clk);
        drive_d(1'b1, 3'b001, 8'h20, 32'h00001234);
        push_d(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        drive_d(1'b0, 3'b001, 8'h20, 32'd0);
        push_d(1'b0, 32'h00001234, 1'b1);
        @(negedge clk);
        drive_d(1'b1, 3'b001, 8'h20, 32'h00008001);
        push_d(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        drive_d(1'b0, 3'b101, 8'h20, 32'd0);
        push_d(1'b0, 32'h00008001, 1'b1);
        @(negedge clk);
        drive_d(1'b0, 3'b001, 8'h20, 32'd0);
        push_d(1'b0, 32'hFFFF8001, 1'b1);
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 8'h00;
            drive_d(1'b0, 3'b010, 8'h04, 32'd0);
            push_d(1'b0, 32'hCAFEF00D, 1'b1);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 8'h00;
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_if_grant: got gnt=%b, required 1", bus.if_gnt);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b0;
        drive_d(1'b1, 3'b010, 8'h30, 32'h12345678);
        #1;
        tests_run++;
        if (bus.d_gnt !== 1'b0 || bus.mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_store_blocked: got gnt=%b wr=%b, required 0 0", bus.d_gnt, bus.mem_write);
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.if_rdata !== 32'd0 || bus.d_rdata !== 32'd0 ||
            bus.if_err !== 1'b0 || bus.d_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got rv=%b/%b rdata=%08h/%08h err=%b/%b, required all 0",
                     bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata, bus.if_err, bus.d_err);
        end
        // Streak must restart from zero: IF only wins on the fifth contended cycle.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 8'h00;
            drive_d(1'b0, 3'b010, 8'h30, 32'd0);
            #1;
            tests_run++;
            if (bus.if_gnt !== (i == 5) || bus.d_gnt !== (i != 5)) begin
                tests_failed++;
                $display("FAIL rstmid_streak%0d: got if_gnt=%b d_gnt=%b, required %b %b",
                         i, bus.if_gnt, bus.d_gnt, (i == 5), (i != 5));
            end
            if (i == 5) push_if(1'b0, 32'h00040914);
            else        push_d(1'b0, 32'h00000000, 1'b1);
        end
        idle();
    endtask

    task automatic test_drain();
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d/%0d pending responses, required 0/0", if_q.size(), d_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        mem_arr[0] = 8'h14; mem_arr[1] = 8'h09; mem_arr[2] = 8'h04; mem_arr[3] = 8'h00;
        mem_arr[4] = 8'h0D; mem_arr[5] = 8'hF0; mem_arr[6] = 8'hFE; mem_arr[7] = 8'hCA;
        bus.if_req = 1'b0; bus.if_addr = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_func3 = 3'b000; bus.d_addr = 8'h00; bus.d_wdata = 32'd0;
        test_reset();
        test_fetch();
        test_streak();
        test_store_load();
        test_errors();
        test_halfword();
        test_reset_mid();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation reached time limit, required completion");
        $fatal(1);
    end
endmodule
